// File: rtl/mult_div_seq.sv
// Iterative shift-add multiplier / restoring divider with start/done handshake.
// Define MD_SIGNED_EN to enable signed operands (magnitude datapath plus FIX state).
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DZ,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvs;
    logic               opr;
    logic               sgn;
    logic               neg_a;
    logic               neg_b;

    logic               sgn_in;
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

`ifdef MD_SIGNED_EN
    always_comb begin
        sgn_in   = signed_op;
        neg_a_in = signed_op & a[WIDTH-1];
        neg_b_in = signed_op & b[WIDTH-1];
        mag_a    = neg_a_in ? -a : a;
        mag_b    = neg_b_in ? -b : b;
    end
`else
    logic unused_signed;
    assign unused_signed = signed_op;

    always_comb begin
        sgn_in   = 1'b0;
        neg_a_in = 1'b0;
        neg_b_in = 1'b0;
        mag_a    = a;
        mag_b    = b;
    end
`endif

    // Multiply: low half of acc holds the multiplier, shifted out LSB first.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // Divide: high half is the remainder, low half shifts dividend out / quotient in.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, dvs} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                     acc[WIDTH-2:0], div_ge};
        step      = opr ? div_next : mul_next;
    end

    logic [2*WIDTH-1:0] fixed;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;

    always_comb begin
        fix_q = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_r = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (opr) begin
            fixed = {fix_r, fix_q};
        end else begin
            fixed = (neg_a ^ neg_b) ? -acc : acc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            div0  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            dvs   <= '0;
            opr   <= 1'b0;
            sgn   <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        div0  <= 1'b0;
                        opr   <= op;
                        sgn   <= sgn_in;
                        neg_a <= neg_a_in;
                        neg_b <= neg_b_in;
                        cnt   <= CW'(WIDTH - 1);
                        if (op) begin
                            acc <= {{WIDTH{1'b0}}, mag_a};
                            dvs <= mag_b;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, mag_b};
                            dvs <= mag_a;
                        end
                        if (op && b == '0) begin
                            state <= S_DZ;
                        end else if (op) begin
                            state <= S_DIV;
                        end else begin
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= step;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (sgn) begin
                        state <= S_FIX;
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= step[2*WIDTH-1:WIDTH];
                        lo    <= step[WIDTH-1:0];
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    hi    <= fixed[2*WIDTH-1:WIDTH];
                    lo    <= fixed[WIDTH-1:0];
                end
                S_DZ: begin
                    // hi/lo deliberately left at their previous values
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    div0  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq (WIDTH=32).
// Signed vectors are exercised only when MD_SIGNED_EN is defined.
module tb_mult_div_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;

    int n_checks = 0;
    int n_fails  = 0;

    mult_div_seq #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .op(op),
        .signed_op(signed_op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .div0(div0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and return in the done cycle (or after timeout).
    task automatic run(input logic o, input logic s,
                       input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busy_bad);
        @(posedge clock); #1;
        start = 1'b1; op = o; signed_op = s; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        busy_bad = 0;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clock); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_bad++;
    endtask

    int lat;
    int bb;
    int pulses;

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0;
        signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        reset = 1'b0;

        run(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2, lat, bb);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_busy", 64'(bb), 64'd0);
        check("mul_res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        check("mul_div0", 64'(div0), 64'd0);
        @(posedge clock); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("mul_hold", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        run(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bb);
        check("mul_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run(1'b1, 1'b0, 32'd5, 32'd9, lat, bb);
        check("div_small", {hi, lo}, {32'd5, 32'd0});

        run(1'b1, 1'b0, 32'd100, 32'd7, lat, bb);
        check("div_lat", 64'(lat), 64'd33);
        check("div_busy", 64'(bb), 64'd0);
        check("div_res", {hi, lo}, {32'd2, 32'd14});

        run(1'b1, 1'b0, 32'd42, 32'd0, lat, bb);
        check("dz_lat", 64'(lat), 64'd2);
        check("dz_div0", 64'(div0), 64'd1);
        check("dz_hilo", {hi, lo}, {32'd2, 32'd14});
        @(posedge clock); #1;
        check("dz_hold", 64'(div0), 64'd1);

        run(1'b0, 1'b0, 32'd123, 32'd0, lat, bb);
        check("mul_b0", {hi, lo}, 64'd0);
        check("div0_clr", 64'(div0), 64'd0);

        run(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, lat, bb);
        check("div_big", {hi, lo}, {32'h0000_FFFF, 32'h0000_FFFF});

        // Second start while busy must be ignored.
        @(posedge clock); #1;
        start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1; op = 1'b1; a = 32'd50; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                pulses++;
                check("hs_res", {hi, lo}, 64'd42);
            end
            @(posedge clock); #1;
        end
        check("hs_pulses", 64'(pulses), 64'd1);

        // Reset in cycle 10 of a divide aborts it.
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("ab_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_hilo", {hi, lo}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(posedge clock); #1;
        end
        check("ab_nodone", 64'(pulses), 64'd0);

        // Start coinciding with reset is lost.
        reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        check("rs_busy", 64'(busy), 64'd0);

        run(1'b1, 1'b0, 32'd1000, 32'd3, lat, bb);
        check("post_lat", 64'(lat), 64'd33);
        check("post_res", {hi, lo}, {32'd1, 32'd333});

`ifdef MD_SIGNED_EN
        run(1'b1, 1'b1, -32'sd7, 32'd2, lat, bb);
        check("sdiv_lat", 64'(lat), 64'd34);
        check("sdiv_busy", 64'(bb), 64'd0);
        check("sdiv_res", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run(1'b0, 1'b1, -32'sd7, 32'd2, lat, bb);
        check("smul_lat", 64'(lat), 64'd34);
        check("smul_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF2);

        run(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb);
        check("sdiv_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
        check("sdiv_ovf_d0", 64'(div0), 64'd0);

        run(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, lat, bb);
        check("udiv_lat", 64'(lat), 64'd33);
        check("udiv_res", {hi, lo}, {32'd1, 32'h7FFF_FFFC});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
